muldiv_sequencer: RTL and testbench

//  Control-unit-facing sequencer for the multi-cycle multiply and divide units.

---
 rtl/muldiv_sequencer_if.sv | 44 ++++
 rtl/muldiv_sequencer.sv | 155 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Signal bundle between the control unit, the sequencer and the multiply/divide units.
// Handshake: OpStart is a one-cycle request strobe that is taken only while Busy=0; Busy is the
// not-ready indication, so a requester holding a request must stall until Busy drops. Unit done
// flags are levels that are sampled only while the sequencer is waiting on that unit.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             OpStart;
  logic             OpDiv;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Abort;
  logic             HiWr;
  logic             LoWr;
  logic [WIDTH-1:0] WrData;
  logic [WIDTH-1:0] MdA;
  logic [WIDTH-1:0] MdB;
  logic             MultStart;
  logic             DivStart;
  logic             MultDone;
  logic             DivDone;
  logic [WIDTH-1:0] MultHi;
  logic [WIDTH-1:0] MultLo;
  logic [WIDTH-1:0] DivHi;
  logic [WIDTH-1:0] DivLo;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic             Timeout;

  modport slave (
    input  OpStart, OpDiv, A, B, Abort, HiWr, LoWr, WrData,
    input  MultDone, DivDone, MultHi, MultLo, DivHi, DivLo,
    output MdA, MdB, MultStart, DivStart, HI, LO, Busy, Done, DivZero, Timeout
  );

  modport master (
    output OpStart, OpDiv, A, B, Abort, HiWr, LoWr, WrData,
    output MultDone, DivDone, MultHi, MultLo, DivHi, DivLo,
    input  MdA, MdB, MultStart, DivStart, HI, LO, Busy, Done, DivZero, Timeout
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Sequences one MULT/DIV request at a time through the external units and owns HI/LO.
// Divide-by-zero is rejected in IDLE; abort drains the in-flight unit and discards its result.
module muldiv_sequencer #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic                clk,
  input  logic                Reset,
  muldiv_sequencer_if.slave   bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             op_div_q, op_div_d;
  logic [WIDTH-1:0] md_a_q, md_a_d;
  logic [WIDTH-1:0] md_b_q, md_b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             mult_start_q, mult_start_d;
  logic             div_start_q, div_start_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic             timeout_q, timeout_d;

  logic             sel_done;
  logic [WIDTH-1:0] sel_hi;
  logic [WIDTH-1:0] sel_lo;

  // Only the unit selected by the latched op bit is listened to.
  assign sel_done = op_div_q ? bus.DivDone : bus.MultDone;
  assign sel_hi   = op_div_q ? bus.DivHi   : bus.MultHi;
  assign sel_lo   = op_div_q ? bus.DivLo   : bus.MultLo;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_div_d     = op_div_q;
    md_a_d       = md_a_q;
    md_b_d       = md_b_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mult_start_d = 1'b0;
    div_start_d  = 1'b0;
    done_d       = 1'b0;
    div_zero_d   = 1'b0;
    timeout_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.HiWr) hi_d = bus.WrData;
        if (bus.LoWr) lo_d = bus.WrData;
        if (bus.OpStart) begin
          if (bus.OpDiv && (bus.B == '0)) begin
            div_zero_d = 1'b1;
          end else begin
            md_a_d       = bus.A;
            md_b_d       = bus.B;
            op_div_d     = bus.OpDiv;
            mult_start_d = ~bus.OpDiv;
            div_start_d  = bus.OpDiv;
            state_d      = S_START;
          end
        end
      end

      S_START: begin
        cnt_d   = 8'd0;
        state_d = bus.Abort ? S_DRAIN : S_WAIT;
      end

      S_WAIT: begin
        if (bus.Abort) begin
          state_d = S_DRAIN;
        end else if (sel_done) begin
          hi_d    = sel_hi;
          lo_d    = sel_lo;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_DRAIN: begin
        // Result of an aborted op is thrown away; we only wait for the unit to go quiet.
        if (sel_done) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      op_div_q     <= 1'b0;
      md_a_q       <= '0;
      md_b_q       <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      mult_start_q <= 1'b0;
      div_start_q  <= 1'b0;
      done_q       <= 1'b0;
      div_zero_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_div_q     <= op_div_d;
      md_a_q       <= md_a_d;
      md_b_q       <= md_b_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mult_start_q <= mult_start_d;
      div_start_q  <= div_start_d;
      done_q       <= done_d;
      div_zero_q   <= div_zero_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.MdA       = md_a_q;
  assign bus.MdB       = md_b_q;
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;
  assign bus.MultStart = mult_start_q;
  assign bus.DivStart  = div_start_q;
  assign bus.Done      = done_q;
  assign bus.DivZero   = div_zero_q;
  assign bus.Timeout   = timeout_q;
  assign bus.Busy      = (state_q != S_IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: the testbench plays both the control unit and the
// multiply/divide units, with hand-computed expected HI/LO and pulse timing.
module tb_muldiv_sequencer;

  localparam int WIDTH = 32;
  localparam int TMO   = 40;

  logic       clk;
  logic       reset_n;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int n_mstart, n_dstart, n_done, n_busy, n_dz;

  muldiv_sequencer_if #(.WIDTH(WIDTH)) ifc ();

  muldiv_sequencer #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .Reset     (reset_n),
    .bus       (ifc.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge and tally output pulses seen there.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ifc.MultStart === 1'b1) n_mstart++;
    if (ifc.DivStart  === 1'b1) n_dstart++;
    if (ifc.Done      === 1'b1) n_done++;
    if (ifc.Busy      === 1'b1) n_busy++;
    if (ifc.DivZero   === 1'b1) n_dz++;
  endtask

  task automatic clear_counts();
    n_mstart = 0; n_dstart = 0; n_done = 0; n_busy = 0; n_dz = 0;
  endtask

  task automatic idle_inputs();
    ifc.OpStart = 0; ifc.OpDiv = 0; ifc.A = '0; ifc.B = '0; ifc.Abort = 0;
    ifc.HiWr = 0; ifc.LoWr = 0; ifc.WrData = '0;
    ifc.MultDone = 0; ifc.DivDone = 0;
    ifc.MultHi = '0; ifc.MultLo = '0; ifc.DivHi = '0; ifc.DivLo = '0;
  endtask

  task automatic issue(input logic is_div, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    ifc.OpDiv = is_div; ifc.A = a; ifc.B = b; ifc.OpStart = 1;
    tick();
    ifc.OpStart = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    #22;
    checks++; if (ifc.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", ifc.Busy); end
    checks++; if ({ifc.HI, ifc.LO} !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h want 0", {ifc.HI, ifc.LO}); end
    checks++; if ({ifc.MdA, ifc.MdB} !== 64'h0) begin errors++; $display("FAIL reset_md: got %h want 0", {ifc.MdA, ifc.MdB}); end
    checks++; if ({ifc.MultStart, ifc.DivStart, ifc.Done, ifc.DivZero, ifc.Timeout} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses: got %b want 00000", {ifc.MultStart, ifc.DivStart, ifc.Done, ifc.DivZero, ifc.Timeout}); end
    reset_n = 1;
    tick();
  endtask

  task automatic test_mult();
    clear_counts();
    issue(1'b0, 32'd7, 32'd6);
    checks++; if (ifc.MultStart !== 1'b1) begin errors++; $display("FAIL mult_start: got %0b want 1", ifc.MultStart); end
    checks++; if ({ifc.MdA, ifc.MdB} !== {32'd7, 32'd6}) begin errors++; $display("FAIL mult_md: got %h want %h", {ifc.MdA, ifc.MdB}, {32'd7, 32'd6}); end
    checks++; if (ifc.Busy !== 1'b1) begin errors++; $display("FAIL mult_busy: got %0b want 1", ifc.Busy); end
    tick(); tick(); tick();
    ifc.MultDone = 1; ifc.MultHi = 32'd0; ifc.MultLo = 32'd42;
    tick();
    ifc.MultDone = 0;
    checks++; if (ifc.Done !== 1'b1) begin errors++; $display("FAIL mult_done: got %0b want 1", ifc.Done); end
    checks++; if (ifc.Busy !== 1'b0) begin errors++; $display("FAIL mult_busy_with_done: got %0b want 0", ifc.Busy); end
    checks++; if ({ifc.HI, ifc.LO} !== {32'd0, 32'd42}) begin errors++; $display("FAIL mult_hilo: got %h want %h", {ifc.HI, ifc.LO}, {32'd0, 32'd42}); end
    tick();
    checks++; if (ifc.Done !== 1'b0) begin errors++; $display("FAIL mult_done_one_cycle: got %0b want 0", ifc.Done); end
    checks++; if (n_mstart != 1 || n_dstart != 0 || n_done != 1) begin
      errors++; $display("FAIL mult_pulse_counts: got mstart=%0d dstart=%0d done=%0d want 1 0 1", n_mstart, n_dstart, n_done); end
  endtask

  task automatic test_divzero();
    clear_counts();
    issue(1'b1, 32'd100, 32'd0);
    checks++; if (ifc.DivZero !== 1'b1) begin errors++; $display("FAIL dz_pulse: got %0b want 1", ifc.DivZero); end
    tick(); tick();
    checks++; if (n_dz != 1) begin errors++; $display("FAIL dz_one_cycle: got %0d pulses want 1", n_dz); end
    checks++; if (n_dstart != 0 || n_busy != 0) begin errors++; $display("FAIL dz_no_start: got dstart=%0d busy=%0d want 0 0", n_dstart, n_busy); end
    checks++; if ({ifc.HI, ifc.LO} !== {32'd0, 32'd42}) begin errors++; $display("FAIL dz_hilo: got %h want %h", {ifc.HI, ifc.LO}, {32'd0, 32'd42}); end
  endtask

  task automatic test_div();
    clear_counts();
    issue(1'b1, 32'd100, 32'd7);
    checks++; if (ifc.DivStart !== 1'b1) begin errors++; $display("FAIL div_start: got %0b want 1", ifc.DivStart); end
    ifc.MultHi = 32'hBAD; ifc.MultLo = 32'hBAD;
    for (int i = 1; i <= 33; i++) begin
      tick();
      ifc.MultDone = (i % 4 == 0);
    end
    ifc.MultDone = 0;
    checks++; if (n_done != 0 || ifc.Busy !== 1'b1) begin errors++; $display("FAIL div_ignore_mult: got done=%0d busy=%0b want 0 1", n_done, ifc.Busy); end
    ifc.DivDone = 1; ifc.DivHi = 32'd2; ifc.DivLo = 32'd14;
    tick();
    ifc.DivDone = 0;
    checks++; if (ifc.Done !== 1'b1) begin errors++; $display("FAIL div_done: got %0b want 1", ifc.Done); end
    checks++; if ({ifc.HI, ifc.LO} !== {32'd2, 32'd14}) begin errors++; $display("FAIL div_hilo: got %h want %h", {ifc.HI, ifc.LO}, {32'd2, 32'd14}); end
    checks++; if (n_dstart != 1 || n_mstart != 0) begin errors++; $display("FAIL div_start_count: got dstart=%0d mstart=%0d want 1 0", n_dstart, n_mstart); end
    tick();
  endtask

  task automatic test_mthi_mtlo();
    ifc.HiWr = 1; ifc.WrData = 32'h11;
    tick();
    ifc.HiWr = 0; ifc.LoWr = 1; ifc.WrData = 32'h22;
    tick();
    ifc.LoWr = 0;
    checks++; if ({ifc.HI, ifc.LO} !== {32'h11, 32'h22}) begin errors++; $display("FAIL mt_hilo: got %h want %h", {ifc.HI, ifc.LO}, {32'h11, 32'h22}); end
  endtask

  task automatic test_timeout();
    int bad;
    issue(1'b1, 32'd5, 32'd3);
    tick();
    bad = 0;
    for (int i = 1; i <= TMO; i++) begin
      tick();
      if (ifc.Timeout !== (i == TMO)) bad++;
      if (ifc.Busy !== (i < TMO)) bad++;
      // HiWr while busy must be dropped.
      ifc.HiWr = (i == 5); ifc.WrData = 32'hFFFF;
    end
    ifc.HiWr = 0;
    checks++; if (bad != 0) begin errors++; $display("FAIL timeout_timing: got %0d bad cycles want 0", bad); end
    checks++; if ({ifc.HI, ifc.LO} !== {32'h11, 32'h22}) begin errors++; $display("FAIL timeout_hilo: got %h want %h", {ifc.HI, ifc.LO}, {32'h11, 32'h22}); end
    tick();
    checks++; if (ifc.Timeout !== 1'b0) begin errors++; $display("FAIL timeout_one_cycle: got %0b want 0", ifc.Timeout); end
  endtask

  task automatic test_abort();
    int bad;
    clear_counts();
    issue(1'b0, 32'd3, 32'd9);
    tick(); tick(); tick();
    ifc.Abort = 1;
    tick();
    ifc.Abort = 0;
    checks++; if (dbg_state !== 2'd3) begin errors++; $display("FAIL abort_drain_state: got %0d want 3", dbg_state); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ifc.Busy !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL abort_busy_hold: got %0d idle cycles want 0", bad); end
    ifc.MultDone = 1; ifc.MultHi = 32'h0; ifc.MultLo = 32'hDEAD;
    tick();
    ifc.MultDone = 0;
    checks++; if (ifc.Busy !== 1'b0) begin errors++; $display("FAIL abort_release: got busy=%0b want 0", ifc.Busy); end
    tick();
    checks++; if (n_done != 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", n_done); end
    checks++; if ({ifc.HI, ifc.LO} !== {32'h11, 32'h22}) begin errors++; $display("FAIL abort_hilo: got %h want %h", {ifc.HI, ifc.LO}, {32'h11, 32'h22}); end
  endtask

  task automatic test_reset_mid_op();
    issue(1'b1, 32'd9, 32'd3);
    tick();
    #2 reset_n = 0;
    #1;
    checks++; if ({ifc.Busy, ifc.HI, ifc.LO, ifc.MdA, ifc.MdB} !== '0) begin
      errors++; $display("FAIL midreset_clear: busy=%0b hi=%h lo=%h mda=%h mdb=%h want all 0", ifc.Busy, ifc.HI, ifc.LO, ifc.MdA, ifc.MdB); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL midreset_state: got %0d want 0", dbg_state); end
    #2 reset_n = 1;
    ifc.HiWr = 1; ifc.WrData = 32'h1234;
    issue(1'b0, 32'd3, 32'd4);
    ifc.HiWr = 0;
    checks++; if (ifc.MultStart !== 1'b1 || ifc.HI !== 32'h1234) begin
      errors++; $display("FAIL hiwr_with_op: got mstart=%0b hi=%h want 1 1234", ifc.MultStart, ifc.HI); end
    tick(); tick();
    checks++; if (ifc.HI !== 32'h1234) begin errors++; $display("FAIL hiwr_hold: got %h want 1234", ifc.HI); end
    ifc.MultDone = 1; ifc.MultHi = 32'h0; ifc.MultLo = 32'd12;
    tick();
    ifc.MultDone = 0;
    checks++; if (ifc.Done !== 1'b1 || {ifc.HI, ifc.LO} !== {32'h0, 32'd12}) begin
      errors++; $display("FAIL hiwr_overwrite: got done=%0b hilo=%h want 1 %h", ifc.Done, {ifc.HI, ifc.LO}, {32'h0, 32'd12}); end
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 32'd8, 32'd8);
    tick();
    ifc.MultDone = 1; ifc.MultHi = 32'h0; ifc.MultLo = 32'd64;
    tick();
    ifc.MultDone = 0;
    checks++; if (ifc.Done !== 1'b1 || ifc.Busy !== 1'b0) begin errors++; $display("FAIL b2b_first_done: got done=%0b busy=%0b want 1 0", ifc.Done, ifc.Busy); end
    issue(1'b1, 32'd50, 32'd5);
    checks++; if (ifc.DivStart !== 1'b1 || ifc.MdA !== 32'd50) begin errors++; $display("FAIL b2b_accept: got dstart=%0b mda=%0d want 1 50", ifc.DivStart, ifc.MdA); end
    checks++; if ({ifc.HI, ifc.LO} !== {32'h0, 32'd64}) begin errors++; $display("FAIL b2b_mult_hilo: got %h want %h", {ifc.HI, ifc.LO}, {32'h0, 32'd64}); end
    tick();
    ifc.DivDone = 1; ifc.DivHi = 32'd0; ifc.DivLo = 32'd10;
    tick();
    ifc.DivDone = 0;
    checks++; if (ifc.Done !== 1'b1 || {ifc.HI, ifc.LO} !== {32'h0, 32'd10}) begin
      errors++; $display("FAIL b2b_div_result: got done=%0b hilo=%h want 1 %h", ifc.Done, {ifc.HI, ifc.LO}, {32'h0, 32'd10}); end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_counts();
    test_reset();
    test_mult();
    test_divzero();
    test_div();
    test_mthi_mtlo();
    test_timeout();
    test_abort();
    test_reset_mid_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
